// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register map and ID constants shared by the interrupt controller.
package int_ctrl_pkg;
  localparam logic [7:0] INT_CTRL_ENABLE    = 8'h00;
  localparam logic [7:0] INT_CTRL_PENDING   = 8'h04;
  localparam logic [7:0] INT_CTRL_TRIGGER   = 8'h08;
  localparam logic [7:0] INT_CTRL_THRESHOLD = 8'h0C;
  localparam logic [7:0] INT_CTRL_CLAIM     = 8'h10;
  localparam logic [7:0] INT_CTRL_PRIO_BASE = 8'h40;
  localparam int INT_ID_W = 8;
  localparam logic [INT_ID_W-1:0] INT_ID_NONE = '0;
endpackage

// File: rtl/gen_ticks_sync.sv
// gen_ticks_sync: DP-stage flop synchroniser for DW asynchronous lines.
module gen_ticks_sync #(
  parameter int DP = 2,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] sync_q [DP];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < DP; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign dout = sync_q[DP-1];
endmodule

// File: rtl/int_gateway.sv
// int_gateway: per-source pending/in-service tracking; INT_CTRL_EDGE_EN adds edge-triggered mode.
module int_gateway (
  input  logic clk,
  input  logic rst_n,
`ifdef INT_CTRL_EDGE_EN
  input  logic edge_mode,
`endif
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);
  logic set;
`ifdef INT_CTRL_EDGE_EN
  logic src_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_q <= 1'b0;
    else src_q <= src;
  end
  assign set = edge_mode ? src & ~src_q : src & ~in_service;
`else
  assign set = src & ~in_service;
`endif
  // a gateway set outranks the claim clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      pending    <= set | (pending & ~claim);
      in_service <= claim | (in_service & ~complete);
    end
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: priority interrupt controller with claim/complete register port.
// Define INT_CTRL_EDGE_EN to add the TRIGGER register and per-source edge mode.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  src_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [7:0]          addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic                int_req_o,
  output logic [INT_ID_W-1:0] int_id_o
);
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC:1] enable, pending, in_service, claim, complete, elig;
  logic [PRIO_W-1:0] threshold, win_prio;
  logic [PRIO_W-1:0] prio [1:NUM_SRC];
  logic [INT_ID_W-1:0] win_id;
  logic [31:0] rdata;
  logic wr, rd, claim_v, unused_data;
`ifdef INT_CTRL_EDGE_EN
  logic [NUM_SRC:1] trigger;
`endif
  assign wr = req_i & we_i;
  assign rd = req_i & ~we_i;
  assign claim_v = rd && addr_i == INT_CTRL_CLAIM && int_id_o != INT_ID_NONE;
  assign unused_data = ^data_i;
  gen_ticks_sync #(.DP(2), .DW(NUM_SRC)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (src_i),
    .dout (src_s)
  );
  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    assign claim[g]    = claim_v && int_id_o == INT_ID_W'(g);
    assign complete[g] = wr && addr_i == INT_CTRL_CLAIM && data_i[7:0] == INT_ID_W'(g);
    assign elig[g]     = pending[g] & enable[g] & ~in_service[g] & (prio[g] > threshold);
    int_gateway u_gw (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef INT_CTRL_EDGE_EN
      .edge_mode (trigger[g]),
`endif
      .src       (src_s[g-1]),
      .claim     (claim[g]),
      .complete  (complete[g]),
      .pending   (pending[g]),
      .in_service(in_service[g])
    );
  end
  // descending scan with >= lets the lowest ID win ties
  always_comb begin
    win_id   = INT_ID_NONE;
    win_prio = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      if (elig[i] && prio[i] >= win_prio) begin
        win_id   = INT_ID_W'(i);
        win_prio = prio[i];
      end
    end
  end
  always_comb begin
    rdata = '0;
    case (addr_i)
      INT_CTRL_ENABLE:    rdata = 32'({enable, 1'b0});
      INT_CTRL_PENDING:   rdata = 32'({pending, 1'b0});
`ifdef INT_CTRL_EDGE_EN
      INT_CTRL_TRIGGER:   rdata = 32'({trigger, 1'b0});
`endif
      INT_CTRL_THRESHOLD: rdata = 32'(threshold);
      INT_CTRL_CLAIM:     rdata = 32'(int_id_o);
      default: ;
    endcase
    for (int i = 1; i <= NUM_SRC; i++)
      if (addr_i == INT_CTRL_PRIO_BASE + 8'(4 * i)) rdata = 32'(prio[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= '0;
      threshold <= '0;
      for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
`ifdef INT_CTRL_EDGE_EN
      trigger   <= '0;
`endif
      data_o    <= '0;
      int_req_o <= 1'b0;
      int_id_o  <= INT_ID_NONE;
    end else begin
      data_o    <= rd ? rdata : '0;
      int_id_o  <= win_id;
      int_req_o <= win_id != INT_ID_NONE;
      if (wr && addr_i == INT_CTRL_ENABLE) enable <= data_i[NUM_SRC:1];
      if (wr && addr_i == INT_CTRL_THRESHOLD) threshold <= data_i[PRIO_W-1:0];
`ifdef INT_CTRL_EDGE_EN
      if (wr && addr_i == INT_CTRL_TRIGGER) trigger <= data_i[NUM_SRC:1];
`endif
      for (int i = 1; i <= NUM_SRC; i++)
        if (wr && addr_i == INT_CTRL_PRIO_BASE + 8'(4 * i)) prio[i] <= data_i[PRIO_W-1:0];
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: randomized and directed scoreboard bench for int_ctrl against a behavioural model.
module tb_int_ctrl;
  localparam int N  = 16;
  localparam int PW = 3;
  localparam logic [31:0] MASK = ((32'd1 << (N + 1)) - 32'd1) & ~32'd1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] src_i = '0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        int_req_o;
  logic [7:0]  int_id_o;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_en, m_pend, m_insv, m_trig, m_s1, m_s2, m_sq;
  int m_prio[32];
  int m_thr, m_id;
  bit m_rd;

  always #5 clk = ~clk;

  int_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .src_i(src_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .int_req_o(int_req_o), .int_id_o(int_id_o)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // highest priority above threshold wins; strict > in ascending ID order keeps the lowest ID on ties
  function automatic int winner();
    int best = 0;
    int bp = 0;
    for (int i = 1; i <= N; i++)
      if (m_pend[i] && m_en[i] && !m_insv[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
        best = i;
        bp = m_prio[i];
      end
    return best;
  endfunction

  function automatic bit is_prio(logic [7:0] a);
    return a >= 8'h44 && int'(a) <= 8'h40 + 4 * N && a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] reg_read(logic [7:0] a);
    if (a == 8'h00) return m_en;
    if (a == 8'h04) return m_pend;
`ifdef INT_CTRL_EDGE_EN
    if (a == 8'h08) return m_trig;
`endif
    if (a == 8'h0C) return 32'(m_thr);
    if (a == 8'h10) return 32'(m_id);
    if (is_prio(a)) return 32'(m_prio[(a - 8'h40) / 4]);
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_insv = 0; m_trig = 0;
    m_s1 = 0; m_s2 = 0; m_sq = 0;
    for (int i = 0; i < 32; i++) m_prio[i] = 0;
    m_thr = 0; m_id = 0; m_rd = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    logic [31:0] set, clr, cmp, rdv;
    int w, cd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    w = winner();
    rdv = reg_read(addr_i);
    set = 0; clr = 0; cmp = 0;
    cd = int'(data_i[7:0]);
    if (req_i && !we_i && addr_i == 8'h10 && m_id != 0) clr[m_id] = 1'b1;
    if (req_i && we_i && addr_i == 8'h10 && cd >= 1 && cd <= N) cmp[cd] = 1'b1;
    for (int i = 1; i <= N; i++) begin
`ifdef INT_CTRL_EDGE_EN
      if (m_trig[i]) set[i] = m_s2[i] & ~m_sq[i]; else
`endif
      set[i] = m_s2[i] & ~m_insv[i];
    end
    m_pend = (set | (m_pend & ~clr)) & MASK;
    m_insv = (m_insv & ~cmp) | clr;
    if (req_i && we_i) begin
      if (addr_i == 8'h00) m_en = data_i & MASK;
`ifdef INT_CTRL_EDGE_EN
      if (addr_i == 8'h08) m_trig = data_i & MASK;
`endif
      if (addr_i == 8'h0C) m_thr = int'(data_i & ((32'd1 << PW) - 1));
      if (is_prio(addr_i)) m_prio[(addr_i - 8'h40) / 4] = int'(data_i & ((32'd1 << PW) - 1));
    end
    m_sq = m_s2;
    m_s2 = m_s1;
    m_s1 = 32'(src_i) << 1;
    m_id = w;
    m_rd = req_i && !we_i;
    if (m_rd) exp_q.push_back(rdv);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents read data, checks outputs every cycle
  initial forever begin
    @(negedge clk);
    if (m_rd) begin
      if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
      else check("data_o", data_o, exp_q.pop_front());
    end else check("data_idle", data_o, 32'd0);
    check("int_id", 32'(int_id_o), 32'(m_id));
    check("int_req", 32'(int_req_o), 32'(m_id != 0));
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic bus(bit w, logic [7:0] a, logic [31:0] d);
    req_i = 1'b1; we_i = w; addr_i = a; data_i = d;
    tick();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    bus(1'b1, a, d);
  endtask

  task automatic rd(logic [7:0] a);
    bus(1'b0, a, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_req", 32'(int_req_o), 32'd0);
    check("reset_id", 32'(int_id_o), 32'd0);
    // basic level interrupt, claim, complete
    wr(8'h00, 32'h4); wr(8'h48, 32'd1); wr(8'h0C, 32'd0);
    src_i[1] = 1'b1;
    repeat (4) tick();
    check("basic_req", 32'(int_req_o), 32'd1);
    check("basic_id", 32'(int_id_o), 32'd2);
    rd(8'h10);
    check("claim_data", data_o, 32'd2);
    tick();
    check("claim_req_fall", 32'(int_req_o), 32'd0);
    repeat (3) tick();
    check("no_rerequest", 32'(int_req_o), 32'd0);
    wr(8'h10, 32'd9);
    tick();
    check("bogus_complete", 32'(int_req_o), 32'd0);
    wr(8'h10, 32'd2);
    tick();
    check("repend_id", 32'(int_id_o), 32'd2);
    // reset mid-operation with ID 2 claimed
    rd(8'h10);
    tick();
    do_reset();
    rd(8'h04); check("rst_pending", data_o, 32'd0);
    rd(8'h00); check("rst_enable", data_o, 32'd0);
    rd(8'h10); check("rst_claim", data_o, 32'd0);
    rd(8'h48); check("rst_prio", data_o, 32'd0);
    check("rst_req", 32'(int_req_o), 32'd0);
    src_i = '0;
    // arbitration and ties
    do_reset();
    wr(8'h00, 32'hA8); wr(8'h4C, 32'd4); wr(8'h54, 32'd4); wr(8'h5C, 32'd6);
    src_i = 16'h0054;
    repeat (4) tick();
    check("arb_first", 32'(int_id_o), 32'd7);
    rd(8'h10); tick();
    check("arb_second", 32'(int_id_o), 32'd3);
    rd(8'h10); tick();
    check("arb_third", 32'(int_id_o), 32'd5);
    src_i = '0;
    // threshold gating
    do_reset();
    wr(8'h00, 32'h2); wr(8'h44, 32'd5); wr(8'h0C, 32'd5);
    src_i[0] = 1'b1;
    repeat (5) tick();
    check("thr_gated", 32'(int_req_o), 32'd0);
    wr(8'h0C, 32'd4); tick();
    check("thr_open_req", 32'(int_req_o), 32'd1);
    check("thr_open_id", 32'(int_id_o), 32'd1);
    src_i = '0;
`ifdef INT_CTRL_EDGE_EN
    do_reset();
    wr(8'h00, 32'h10); wr(8'h50, 32'd2); wr(8'h08, 32'h10);
    src_i[3] = 1'b1; tick(); src_i[3] = 1'b0;
    repeat (3) tick();
    rd(8'h04); check("edge_pend", data_o, 32'h10);
    rd(8'h10); check("edge_claim", data_o, 32'd4);
    src_i[3] = 1'b1; tick(); src_i[3] = 1'b0; tick(); tick();
    rd(8'h04); check("edge_inservice_repend", data_o, 32'h10);
    wr(8'h10, 32'd4); tick();
    check("edge_after_complete", 32'(int_id_o), 32'd4);
    src_i[3] = 1'b1; tick(); src_i[3] = 1'b0; tick();
    rd(8'h10); check("edge_claim2", data_o, 32'd4);
    rd(8'h04); check("edge_claim_cycle_pend", data_o, 32'h10);
`endif
    // randomized traffic against the model
    do_reset();
    wr(8'h00, 32'hFFFF_FFFF);
    for (int i = 1; i <= N; i++) wr(8'(8'h40 + 4 * i), 32'($urandom_range(0, 7)));
    for (int c = 0; c < 1500; c++) begin
      src_i = src_i ^ N'($urandom & $urandom & $urandom);
      case ($urandom_range(0, 9))
        0, 1: rd(8'h10);
        2: wr(8'h10, 32'($urandom_range(0, 20)));
        3, 4: begin
          a = 8'($urandom_range(0, 47)) << 2;
          if ($urandom_range(0, 1) == 0) rd(a);
          else wr(a, $urandom);
        end
        5: wr(8'(8'h40 + 4 * $urandom_range(1, N)), 32'($urandom_range(0, 7)));
        6: wr(8'h0C, 32'($urandom_range(0, 3)));
        default: tick();
      endcase
    end
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
